mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the shared memory-mapped I/O bus.
- Master 0 is the CPU data port. Master 1 is a secondary requester, such as a debug loader or DMA.
- The slave side drives the mmio block's memread/memwrite/addr/writedata/readdata interface.
- Serialises accesses with round-robin fairness and adds a ready handshake, so masters stall until their transaction completes.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared MMIO bus bundle: two requesting masters on one side, the memory-mapped slave on the other.
interface mem_arbiter_if;
  logic        m0_memread;
  logic        m0_memwrite;
  logic [31:0] m0_addr;
  logic [31:0] m0_writedata;
  logic [31:0] m0_readdata;
  logic        m0_ready;

  logic        m1_memread;
  logic        m1_memwrite;
  logic [31:0] m1_addr;
  logic [31:0] m1_writedata;
  logic [31:0] m1_readdata;
  logic        m1_ready;

  logic        memread;
  logic        memwrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  // master: the arbiter, which owns the slave strobes and answers the requesters
  modport master (
    input  m0_memread, m0_memwrite, m0_addr, m0_writedata,
    input  m1_memread, m1_memwrite, m1_addr, m1_writedata,
    input  mem_readdata,
    output m0_readdata, m0_ready, m1_readdata, m1_ready,
    output memread, memwrite, mem_addr, mem_writedata
  );

  // slave: the requesters plus the memory, as seen from outside the arbiter
  modport slave (
    output m0_memread, m0_memwrite, m0_addr, m0_writedata,
    output m1_memread, m1_memwrite, m1_addr, m1_writedata,
    output mem_readdata,
    input  m0_readdata, m0_ready, m1_readdata, m1_ready,
    input  memread, memwrite, mem_addr, mem_writedata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-master arbiter for the MMIO slave; one strobe per transaction, one-cycle ready pulse.
// Write completes 2 cycles after the request is sampled, read 2+RD_LATENCY; masters stall until ready.
module mem_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input logic           clk,
  input logic           reset_n,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] CNT_INIT = (RD_LATENCY > 0) ? 3'(RD_LATENCY - 1) : 3'd0;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic              last_q, last_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              memread_q, memread_d;
  logic              memwrite_q, memwrite_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        rdy_q, rdy_d;
  logic [1:0][31:0]  rdata_q, rdata_d;

  logic req0, req1, pick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      wr_q       <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= 3'd0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdy_q      <= 2'b00;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      wr_q       <= wr_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdy_q      <= rdy_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    wr_d       = wr_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdy_d      = 2'b00;
    rdata_d    = rdata_q;
    req0       = bus.m0_memread | bus.m0_memwrite;
    req1       = bus.m1_memread | bus.m1_memwrite;
    pick       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          // On a tie the master that did not go last wins
          pick       = (req0 & req1) ? ~last_q : req1;
          gnt_d      = pick;
          wr_d       = pick ? bus.m1_memwrite : bus.m0_memwrite;
          addr_d     = pick ? bus.m1_addr : bus.m0_addr;
          wdata_d    = pick ? bus.m1_writedata : bus.m0_writedata;
          memwrite_d = wr_d;
          memread_d  = ~wr_d;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          rdy_d[gnt_q] = 1'b1;
          state_d      = RESP;
        end else if (RD_LATENCY == 0) begin
          rdata_d[gnt_q] = bus.mem_readdata;
          rdy_d[gnt_q]   = 1'b1;
          state_d        = RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d[gnt_q] = bus.mem_readdata;
          rdy_d[gnt_q]   = 1'b1;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        // Requests seen here still belong to the finished transaction
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.memread       = memread_q;
  assign bus.memwrite      = memwrite_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_writedata = wdata_q;
  assign bus.m0_ready      = rdy_q[0];
  assign bus.m1_ready      = rdy_q[1];
  assign bus.m0_readdata   = rdata_q[0];
  assign bus.m1_readdata   = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences, random traffic vs a transaction-level model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter_if bus0 ();
  mem_arbiter_if bus3 ();

  mem_arbiter #(.RD_LATENCY(1)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
  mem_arbiter #(.RD_LATENCY(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  mem_arbiter #(.RD_LATENCY(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Slave: data is valid only in exactly the RD_LATENCY-th cycle after the strobe
  localparam logic [31:0] JUNK = 32'hDEAD_0000;
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a == 32'h20) ? 32'h1234_5678 : {a[15:0], ~a[15:0]};
  endfunction

  int age1 = 0;
  int age3 = 0;
  logic [31:0] sv1 = 32'd0;
  logic [31:0] sv3 = 32'd0;
  always @(posedge clk) begin
    if (bus.memread) begin age1 <= 1; sv1 <= bus.mem_addr; end
    else if (age1 != 0 && age1 < 15) age1 <= age1 + 1;
    if (bus3.memread) begin age3 <= 1; sv3 <= bus3.mem_addr; end
    else if (age3 != 0 && age3 < 15) age3 <= age3 + 1;
  end
  assign bus.mem_readdata  = (age1 == 1) ? rd_val(sv1) : JUNK;
  assign bus3.mem_readdata = (age3 == 3) ? rd_val(sv3) : JUNK;
  assign bus0.mem_readdata = bus0.memread ? rd_val(bus0.mem_addr) : JUNK;

  // Bus monitor on the main instance
  int mcyc = 0;
  int last_stb = -100;
  int n_stb = 0;
  int n_rdy0 = 0;
  int n_rdy1 = 0;
  logic        stb_wr = 1'b0;
  logic [31:0] stb_addr = 32'd0;
  logic [31:0] stb_dat = 32'd0;
  always @(negedge clk) begin
    mcyc++;
    if (!reset_n) last_stb = -100;
    else begin
      if (bus.memread || bus.memwrite) begin
        chk("strobe_excl", 32'(bus.memread & bus.memwrite), 32'd0);
        chk("strobe_gap", 32'(mcyc - last_stb >= 3), 32'd1);
        last_stb = mcyc;
        n_stb++;
        stb_wr   = bus.memwrite;
        stb_addr = bus.mem_addr;
        stb_dat  = bus.mem_writedata;
      end
      if (bus.m0_ready || bus.m1_ready) begin
        chk("ready_excl", 32'(bus.m0_ready & bus.m1_ready), 32'd0);
        n_rdy0 += int'(bus.m0_ready);
        n_rdy1 += int'(bus.m1_ready);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit m, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (m) begin
      bus.m1_memread = rd; bus.m1_memwrite = wr; bus.m1_addr = a; bus.m1_writedata = d;
    end else begin
      bus.m0_memread = rd; bus.m0_memwrite = wr; bus.m0_addr = a; bus.m0_writedata = d;
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_memread"}, 32'(bus.memread), 32'd0);
    chk({p, "_memwrite"}, 32'(bus.memwrite), 32'd0);
    chk({p, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({p, "_mem_wdata"}, bus.mem_writedata, 32'd0);
    chk({p, "_m0_ready"}, 32'(bus.m0_ready), 32'd0);
    chk({p, "_m1_ready"}, 32'(bus.m1_ready), 32'd0);
    chk({p, "_m0_rdata"}, bus.m0_readdata, 32'd0);
    chk({p, "_m1_rdata"}, bus.m1_readdata, 32'd0);
  endtask

  typedef struct {
    bit          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    int  s0 = n_stb;
    int  r0 = n_rdy0;
    int  r1 = n_rdy1;
    int  t = 0;
    bit  got = 1'b0;
    drive(v.m, !v.wr, v.wr, v.addr, v.wdat);
    while (!got && t < 20) begin
      step();
      t++;
      got = v.m ? bus.m1_ready : bus.m0_ready;
    end
    chk({nm, "_latency"}, 32'(t), 32'(v.lat));
    chk({nm, "_strobes"}, 32'(n_stb - s0), 32'd1);
    chk({nm, "_stb_addr"}, stb_addr, v.addr);
    chk({nm, "_stb_is_wr"}, 32'(stb_wr), 32'(v.wr));
    if (v.wr) chk({nm, "_stb_wdata"}, stb_dat, v.wdat);
    chk({nm, "_rdata"}, v.m ? bus.m1_readdata : bus.m0_readdata, v.rd);
    chk({nm, "_other_ready"}, 32'(v.m ? n_rdy0 - r0 : n_rdy1 - r1), 32'd0);
    drive(v.m, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
  endtask

  function automatic void idle_all();
    bus.m0_memread = 0;  bus.m0_memwrite = 0;  bus.m0_addr = 0;  bus.m0_writedata = 0;
    bus.m1_memread = 0;  bus.m1_memwrite = 0;  bus.m1_addr = 0;  bus.m1_writedata = 0;
    bus0.m0_memread = 0; bus0.m0_memwrite = 0; bus0.m0_addr = 0; bus0.m0_writedata = 0;
    bus0.m1_memread = 0; bus0.m1_memwrite = 0; bus0.m1_addr = 0; bus0.m1_writedata = 0;
    bus3.m0_memread = 0; bus3.m0_memwrite = 0; bus3.m0_addr = 0; bus3.m0_writedata = 0;
    bus3.m1_memread = 0; bus3.m1_memwrite = 0; bus3.m1_addr = 0; bus3.m1_writedata = 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[5];
  int s0, r0, r1, t0, t3, cnt, first;
  int own[4];
  logic [31:0] rd0, rd3;
  // random-phase model state
  bit          p_vld[2], p_wr[2], p_both[2], saw[2];
  logic [31:0] p_addr[2], p_dat[2], exp_rd[2];
  bit          act, g_wr, g_m, last, pick;
  int          g_edge, r_cyc, free_edge, c;
  logic [31:0] g_addr, exp_addr, exp_wdat;
  bit          e_rd, e_wr, e_r0, e_r1;

  initial begin
    vt[0] = '{1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2, 32'h0};
    vt[1] = '{1'b1, 1'b0, 32'h20, 32'h0,         3, 32'h1234_5678};
    vt[2] = '{1'b0, 1'b0, 32'h40, 32'h0,         3, 32'h0040_FFBF};
    vt[3] = '{1'b1, 1'b1, 32'h24, 32'h0BAD_F00D, 2, 32'h1234_5678};
    vt[4] = '{1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, 2, 32'h0040_FFBF};

    idle_all();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    step();
    chk_zero("reset");
    reset_n = 1'b1;
    s0 = n_stb; r0 = n_rdy0; r1 = n_rdy1;
    repeat (10) step();
    chk("idle_strobes", 32'(n_stb - s0), 32'd0);
    chk("idle_ready", 32'(n_rdy0 - r0 + n_rdy1 - r1), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Read latency 0 and 3 instances
    bus0.m1_memread = 1'b1; bus0.m1_addr = 32'h20;
    bus3.m1_memread = 1'b1; bus3.m1_addr = 32'h20;
    t0 = 0; t3 = 0; rd0 = 32'd0; rd3 = 32'd0;
    for (int t = 1; t <= 12; t++) begin
      step();
      if (bus0.m1_ready && t0 == 0) begin t0 = t; rd0 = bus0.m1_readdata; bus0.m1_memread = 1'b0; end
      if (bus3.m1_ready && t3 == 0) begin t3 = t; rd3 = bus3.m1_readdata; bus3.m1_memread = 1'b0; end
    end
    chk("lat0_latency", 32'(t0), 32'd2);
    chk("lat0_rdata", rd0, 32'h1234_5678);
    chk("lat0_rdata_held", bus0.m1_readdata, 32'h1234_5678);
    chk("lat3_latency", 32'(t3), 32'd5);
    chk("lat3_rdata", rd3, 32'h1234_5678);
    chk("lat3_rdata_held", bus3.m1_readdata, 32'h1234_5678);

    // Master address changes while its read waits for data
    drive(0, 1, 0, 32'h10, 32'h0);
    step();
    chk("addrchg_issue_strobe", 32'(bus.memread), 32'd1);
    chk("addrchg_issue_addr", bus.mem_addr, 32'h10);
    step();
    bus.m0_addr = 32'h30;
    step();
    chk("addrchg_ready", 32'(bus.m0_ready), 32'd1);
    chk("addrchg_mem_addr", bus.mem_addr, 32'h10);
    chk("addrchg_rdata", bus.m0_readdata, 32'h0010_FFEF);
    drive(0, 0, 0, 32'h0, 32'h0);
    step();

    // Reset during the WAIT of an m1 read
    r1 = n_rdy1;
    drive(1, 1, 0, 32'h44, 32'h0);
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    drive(0, 1, 0, 32'h50, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    first = -1; cnt = 0;
    while (first < 0 && cnt < 20) begin
      step();
      cnt++;
      if (bus.m0_ready) first = 0;
      else if (bus.m1_ready) first = 1;
    end
    chk("midreset_first_grant", 32'(first), 32'd0);
    chk("midreset_latency", 32'(cnt), 32'd3);
    chk("midreset_m0_rdata", bus.m0_readdata, 32'h0050_FFAF);
    chk("midreset_no_m1_ready", 32'(n_rdy1 - r1), 32'd0);
    drive(0, 0, 0, 32'h0, 32'h0);
    cnt = 0;
    while (!bus.m1_ready && cnt < 20) begin step(); cnt++; end
    chk("midreset_m1_served", 32'(bus.m1_ready), 32'd1);
    chk("midreset_m1_rdata", bus.m1_readdata, 32'h0044_FFBB);
    drive(1, 0, 0, 32'h0, 32'h0);
    step();

    // Both masters request continuously from reset
    idle_all();
    reset_n = 1'b0;
    step();
    drive(0, 0, 1, 32'h100, 32'h1);
    drive(1, 0, 1, 32'h200, 32'h2);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) own[i] = -1;
    cnt = 0;
    for (int t = 0; t < 40 && cnt < 4; t++) begin
      step();
      if (bus.m0_ready) begin own[cnt] = 0; cnt++; bus.m0_addr = bus.m0_addr + 32'd4; end
      else if (bus.m1_ready) begin own[cnt] = 1; cnt++; bus.m1_addr = bus.m1_addr + 32'd4; end
    end
    for (int i = 0; i < 4; i++) chk($sformatf("grant_order%0d", i), 32'(own[i]), 32'(i % 2));
    idle_all();
    step();

    // Random traffic against a transaction-level model
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int x = 0; x < 2; x++) begin
      p_vld[x] = 0; p_wr[x] = 0; p_both[x] = 0; p_addr[x] = 0; p_dat[x] = 0; exp_rd[x] = 0;
    end
    act = 0; last = 1; free_edge = 0; g_edge = 0; r_cyc = 0; g_wr = 0; g_m = 0;
    g_addr = 0; exp_addr = 0; exp_wdat = 0;
    for (int k = 0; k < 600; k++) begin
      c = k - 1;
      e_rd = act && c == g_edge && !g_wr;
      e_wr = act && c == g_edge && g_wr;
      e_r0 = act && c == r_cyc && g_m == 1'b0;
      e_r1 = act && c == r_cyc && g_m == 1'b1;
      if (act && c == r_cyc && !g_wr) exp_rd[g_m] = rd_val(g_addr);
      chk("rnd_memread", 32'(bus.memread), 32'(e_rd));
      chk("rnd_memwrite", 32'(bus.memwrite), 32'(e_wr));
      chk("rnd_mem_addr", bus.mem_addr, exp_addr);
      chk("rnd_mem_wdata", bus.mem_writedata, exp_wdat);
      chk("rnd_m0_ready", 32'(bus.m0_ready), 32'(e_r0));
      chk("rnd_m1_ready", 32'(bus.m1_ready), 32'(e_r1));
      chk("rnd_m0_rdata", bus.m0_readdata, exp_rd[0]);
      chk("rnd_m1_rdata", bus.m1_readdata, exp_rd[1]);
      saw[0] = e_r0;
      saw[1] = e_r1;
      if (act && c == r_cyc) begin act = 0; free_edge = r_cyc + 2; end
      for (int x = 0; x < 2; x++) begin
        if (saw[x]) p_vld[x] = 0;
        if (!p_vld[x] && $urandom_range(2) == 0) begin
          p_vld[x]  = 1;
          p_wr[x]   = 1'($urandom_range(1));
          p_both[x] = p_wr[x] & 1'($urandom_range(1));
          p_addr[x] = {22'd0, 8'($urandom_range(255)), 2'b00};
          p_dat[x]  = $urandom;
        end
      end
      bus.m0_memread   = p_vld[0] & (!p_wr[0] | p_both[0]);
      bus.m0_memwrite  = p_vld[0] & p_wr[0];
      bus.m0_addr      = p_addr[0];
      bus.m0_writedata = p_dat[0];
      bus.m1_memread   = p_vld[1] & (!p_wr[1] | p_both[1]);
      bus.m1_memwrite  = p_vld[1] & p_wr[1];
      bus.m1_addr      = p_addr[1];
      bus.m1_writedata = p_dat[1];
      if (!act && k >= free_edge && (p_vld[0] || p_vld[1])) begin
        pick     = (p_vld[0] && p_vld[1]) ? !last : p_vld[1];
        last     = pick;
        act      = 1;
        g_m      = pick;
        g_wr     = p_wr[pick];
        g_addr   = p_addr[pick];
        exp_addr = p_addr[pick];
        exp_wdat = p_dat[pick];
        g_edge   = k;
        r_cyc    = k + 1 + (g_wr ? 0 : 1);
      end
      step();
    end

    idle_all();
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
